// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three buses around the memory port arbiter:
//   - CPU side    : cpu_req/we/addr/wdata in, cpu_ack/rdata/stall out
//   - loader side : dma_req/we/addr/wdata in, dma_ack/rdata out
//   - memory side : mem_en/we/addr/wdata out, mem_rdata in
// The slave modport is the arbiter's view. The master modport is the view
// of everything around it: the requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the unified instruction/data memory between the multicycle CPU
// and the program-loader/DMA port. Each access is sequenced as
// grant (IDLE) -> address phase (ACCESS) -> read-latency wait (WAIT) ->
// response (DONE). Ties are broken round-robin.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - mem_port_arbiter_if.slave: CPU request/ack/rdata/stall,
//            loader request/ack/rdata, memory strobe/we/addr/wdata/rdata
// Parameters:
//   AW, DW  - address / data width
//   RD_LAT  - memory read latency (1..4) from the mem_en cycle
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_DMA = 1'b1;
    // Number of WAIT cycles still to go after the address phase.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t        state;
    logic          owner;
    logic          last_grant;
    logic          pick_dma;
    logic [1:0]    wait_cnt;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          cpu_ack_q;
    logic          dma_ack_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    // Round-robin pick: a lone requester wins; on a tie the one that was
    // not granted last time wins.
    always_comb begin
        pick_dma = 1'b0;
        if (bus.cpu_req && bus.dma_req) begin
            pick_dma = (last_grant == OWNER_CPU);
        end else begin
            pick_dma = bus.dma_req;
        end
    end

    // Access sequencer. mem_addr/mem_wdata double as the latched request
    // fields, so they naturally hold their last value outside ACCESS.
    // The read data capture and the owner's ack are set on the same edge
    // so the ack and its data appear together in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWNER_CPU;
            last_grant  <= OWNER_DMA;
            wait_cnt    <= 2'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    if (bus.cpu_req || bus.dma_req) begin
                        owner      <= pick_dma;
                        last_grant <= pick_dma;
                        mem_en_q   <= 1'b1;
                        if (pick_dma) begin
                            mem_we_q    <= bus.dma_we;
                            mem_addr_q  <= bus.dma_addr;
                            mem_wdata_q <= bus.dma_wdata;
                        end else begin
                            mem_we_q    <= bus.cpu_we;
                            mem_addr_q  <= bus.cpu_addr;
                            mem_wdata_q <= bus.cpu_wdata;
                        end
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        cpu_ack_q <= (owner == OWNER_CPU);
                        dma_ack_q <= (owner == OWNER_DMA);
                        state     <= DONE;
                    end else if (RD_LAT > 1) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end else begin
                        if (owner == OWNER_DMA) begin
                            dma_rdata_q <= bus.mem_rdata;
                        end else begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end
                        cpu_ack_q <= (owner == OWNER_CPU);
                        dma_ack_q <= (owner == OWNER_DMA);
                        state     <= DONE;
                    end
                end

                // wait_cnt counts the WAIT cycles left; data is valid
                // during the last one.
                WAIT: begin
                    if (wait_cnt == 2'd1) begin
                        if (owner == OWNER_DMA) begin
                            dma_rdata_q <= bus.mem_rdata;
                        end else begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end
                        cpu_ack_q <= (owner == OWNER_CPU);
                        dma_ack_q <= (owner == OWNER_DMA);
                        wait_cnt  <= 2'd0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                DONE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
endmodule
